// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : UART shared types, frame constants and baud-period helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_PARITY  = 3'd3,
        RX_STOP    = 3'd4,
        RX_WAIT_HI = 3'd5
    } uart_rx_state_t;

    localparam int UART_FRAME_BITS = 8;

    function automatic int baud_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the idle-high UART line.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined)
//                with one-entry valid/ready holding register.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_in,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] status_leds
);
    import uart_pkg::*;

    localparam int c_BAUD_PERIOD = baud_period(CLK_FREQ, BAUD_RATE);
    localparam int c_HALF_PERIOD = c_BAUD_PERIOD / 2;
    localparam int c_CNT_W       = (c_BAUD_PERIOD > 1) ? $clog2(c_BAUD_PERIOD) : 1;

    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_BAUD_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_PERIOD - 1);
    localparam logic [2:0]         c_LAST_BIT  = 3'(UART_FRAME_BITS - 1);

    localparam logic [2:0] c_S_IDLE    = RX_IDLE;
    localparam logic [2:0] c_S_START   = RX_START;
    localparam logic [2:0] c_S_DATA    = RX_DATA;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY  = RX_PARITY;
`endif
    localparam logic [2:0] c_S_STOP    = RX_STOP;
    localparam logic [2:0] c_S_WAIT_HI = RX_WAIT_HI;

    logic                  w_rx_s;
    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_baud_cnt;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_commit;
    logic                  r_frame_err;
    logic [7:0]            r_rx_data;
    logic                  r_rx_valid;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] r_leds;
`ifdef UART_RX_PARITY_EN
    logic                  r_parity_bad;
    logic                  r_parity_err;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (rx_in),
        .o_sync  (w_rx_s)
    );

    // Frame sequencer: r_commit marks a good stop bit; delivery happens next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_commit     <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bad <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                c_S_IDLE: begin
                    r_baud_cnt <= '0;
                    if (!w_rx_s) r_state <= c_S_START;
                end
                c_S_START: begin
                    if (r_baud_cnt == c_HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                        r_parity_bad <= 1'b0;
`endif
                        r_state    <= w_rx_s ? c_S_IDLE : c_S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
                    end
                end
                c_S_DATA: begin
                    if (r_baud_cnt == c_BAUD_LAST) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_S_PARITY;
`else
                            r_state <= c_S_STOP;
`endif
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_S_PARITY: begin
                    if (r_baud_cnt == c_BAUD_LAST) begin
                        r_baud_cnt   <= '0;
                        r_parity_bad <= (^r_shift) ^ w_rx_s;
                        r_state      <= c_S_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
                    end
                end
`endif
                c_S_STOP: begin
                    if (r_baud_cnt == c_BAUD_LAST) begin
                        r_baud_cnt <= '0;
                        // A bad stop bit outranks a parity mismatch.
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_S_WAIT_HI;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (r_parity_bad) begin
                            r_parity_err <= 1'b1;
                            r_state      <= c_S_IDLE;
                        end
`endif
                        else begin
                            r_commit <= 1'b1;
                            r_state  <= c_S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
                    end
                end
                c_S_WAIT_HI: begin
                    r_baud_cnt <= '0;
                    if (w_rx_s) r_state <= c_S_IDLE;
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_state    <= c_S_IDLE;
                end
            endcase
        end
    end

    // Holding register: a commit may refill in the same cycle the old byte is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_leds     <= '0;
        end else begin
            r_overrun <= 1'b0;
            if (r_commit) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                    r_leds     <= r_shift[DATA_WIDTH-1:0];
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign status_leds = r_leds;
    assign busy        = (r_state != c_S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err  = r_parity_err;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Scoreboard bench for uart_receiver (16 clk per bit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

    localparam int BIT_CLKS = 16;
    localparam int K_FRAME = 1, K_OVERRUN = 2, K_PARITY = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;
    logic [3:0] status_leds;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_bytes[$];
    int         exp_flags[$];
    bit         held = 1'b0;
    bit         busy_seen = 1'b0;

    uart_receiver #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .rx_in(rx_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun), .busy(busy),
        .status_leds(status_leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic pop_flag(input int kind, input string nm);
        int k;
        checks++;
        if (exp_flags.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse, required none", nm);
        end else begin
            k = exp_flags.pop_front();
            if (k != kind) begin
                errors++;
                $display("FAIL %s: got flag kind %0d required kind %0d", nm, kind, k);
            end
        end
    endtask

    // Monitor: compares every handshake and every error pulse against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (busy) busy_seen = 1'b1;
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL byte: unexpected byte %0h, required none", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_bytes.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, e});
                    check("status_leds", {28'd0, status_leds}, {28'd0, e[3:0]});
                end
            end
            if (frame_err)  pop_flag(K_FRAME, "frame_err");
            if (overrun)    pop_flag(K_OVERRUN, "overrun");
            if (parity_err) pop_flag(K_PARITY, "parity_err");
        end
    end

    task automatic hold_line(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives a frame; with stop_lo>0 the stop bit is held low and the line is left low.
    task automatic send_frame(input logic [7:0] b, input int stop_lo, input bit bad_par);
        hold_line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold_line(b[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold_line((^b) ^ bad_par, BIT_CLKS);
`else
        if (bad_par) $display("note: parity disabled, bad parity ignored");
`endif
        if (stop_lo > 0) hold_line(1'b0, stop_lo);
        else begin
            hold_line(1'b1, BIT_CLKS);
            hold_line(1'b1, 4);
        end
    endtask

    // Reference model for a well-formed frame: one holding slot, drop when full.
    task automatic send_good(input logic [7:0] b);
        if (rx_ready) exp_bytes.push_back(b);
        else if (!held) begin
            exp_bytes.push_back(b);
            held = 1'b1;
        end else exp_flags.push_back(K_OVERRUN);
        send_frame(b, 0, 1'b0);
    endtask

    task automatic send_frame_err(input logic [7:0] b, input int lo);
        exp_flags.push_back(K_FRAME);
        send_frame(b, lo, 1'b0);
        check("busy_wait_hi", {31'd0, busy}, 32'd1);
        hold_line(1'b1, 8);
        check("busy_after_break", {31'd0, busy}, 32'd0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #3 rx_ready = v;
        if (v) held = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb;
        repeat (3) @(negedge clk);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_leds", {28'd0, status_leds}, 32'd0);
        check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte with consumer ready
        send_good(8'hA5);
        check("leds_a5", {28'd0, status_leds}, 32'h5);
        check("valid_taken", {31'd0, rx_valid}, 32'd0);

        // Start-bit glitch
        busy_seen = 1'b0;
        hold_line(1'b0, 5);
        hold_line(1'b1, 20);
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);

        // Stop bit stuck low
        send_frame_err(8'h3C, 40);
        check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);

        // Overrun with consumer stalled
        set_ready(1'b0);
        send_good(8'h11);
        send_good(8'h22);
        check("held_data", {24'd0, rx_data}, 32'h11);
        check("held_valid", {31'd0, rx_valid}, 32'd1);
        set_ready(1'b1);
        hold_line(1'b1, 4);

        // Reset during bit 3 of 0xFF
        hold_line(1'b0, BIT_CLKS);
        hold_line(1'b1, 3 * BIT_CLKS + 8);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_leds", {28'd0, status_leds}, 32'd0);
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        @(negedge clk);
        hold_line(1'b1, 3);
        reset_n = 1'b1;
        hold_line(1'b1, 4);
        send_good(8'h5A);
        check("post_rst_leds", {28'd0, status_leds}, 32'hA);

`ifdef UART_RX_PARITY_EN
        exp_flags.push_back(K_PARITY);
        send_frame(8'h07, 0, 1'b1);
        check("par_no_valid", {31'd0, rx_valid}, 32'd0);
`else
        send_good(8'h07);
`endif

        // Randomized frames, stalls and framing errors
        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom);
            set_ready(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) send_frame_err(rb, int'($urandom_range(16, 30)));
            else send_good(rb);
        end
        set_ready(1'b1);
        hold_line(1'b1, 10);

        check("bytes_drained", exp_bytes.size(), 32'd0);
        check("flags_drained", exp_flags.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
